// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 8-bit ALU. It buffers commands, runs them against an internal accumulator and returns results in order.
// Optional macro ALU_SEQ_STICKY_CARRY_EN adds the sticky_carry output and the sticky_clr input.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_opcode,
    input  logic [7:0] cmd_operand,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic [7:0] acc,
`ifdef ALU_SEQ_STICKY_CARRY_EN
    output logic       sticky_carry,
    input  logic       sticky_clr,
`endif
    output logic       busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_next;

    // Each entry packs {load, opcode, operand}
    logic [11:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, empty, push, pop;
    logic             head_load;
    logic [2:0]       head_op;
    logic [7:0]       head_operand;

    logic issue_alu, issue_load, capture, rsp_done;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    assign head_load    = fifo_mem[rd_ptr][11];
    assign head_op      = fifo_mem[rd_ptr][10:8];
    assign head_operand = fifo_mem[rd_ptr][7:0];

    assign busy = (state != IDLE) || !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {cmd_load, cmd_opcode, cmd_operand};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A response handshake may pop and issue the next command on the same edge
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue_alu  = 1'b0;
        issue_load = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    issue_load = head_load;
                    issue_alu  = !head_load;
                    state_next = head_load ? RESP : EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_done = 1'b1;
                    if (!empty) begin
                        pop        = 1'b1;
                        issue_load = head_load;
                        issue_alu  = !head_load;
                        state_next = head_load ? RESP : EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_valid  <= 1'b0;
        end else begin
            if (issue_alu) begin
                alu_a      <= acc;
                alu_b      <= head_operand;
                alu_opcode <= head_op;
            end
            if (issue_load) begin
                acc        <= head_operand;
                rsp_result <= head_operand;
                rsp_carry  <= 1'b0;
                rsp_zero   <= (head_operand == 8'h00);
            end
            if (capture) begin
                acc        <= alu_result;
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
                rsp_zero   <= (alu_result == 8'h00);
            end
            if (issue_load || capture)
                rsp_valid <= 1'b1;
            else if (rsp_done)
                rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_SEQ_STICKY_CARRY_EN
    // Setting wins over a clear arriving on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sticky_carry <= 1'b0;
        else if (capture && alu_carry)
            sticky_carry <= 1'b1;
        else if (sticky_clr)
            sticky_carry <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural ALU attached.
// The sticky-carry steps are included when ALU_SEQ_STICKY_CARRY_EN is defined.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_load = 1'b0;
    logic [2:0] cmd_opcode = 3'd0;
    logic [7:0] cmd_operand = 8'd0;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic       rsp_carry, rsp_zero;
    logic [7:0] acc;
    logic       busy;
`ifdef ALU_SEQ_STICKY_CARRY_EN
    logic       sticky_carry;
    logic       sticky_clr = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .acc(acc),
`ifdef ALU_SEQ_STICKY_CARRY_EN
        .sticky_carry(sticky_carry), .sticky_clr(sticky_clr),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference combinational ALU
    logic [8:0] alu_t;
    always_comb begin
        alu_t = 9'd0;
        case (alu_opcode)
            3'd0: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2: alu_t = {1'b0, alu_a & alu_b};
            3'd3: alu_t = {1'b0, alu_a | alu_b};
            3'd4: alu_t = {1'b0, alu_a ^ alu_b};
            3'd5: alu_t = {1'b0, ~alu_a};
            3'd6: alu_t = {1'b0, alu_a} + 9'd1;
            default: alu_t = {alu_a, 1'b0};
        endcase
    end
    assign alu_result = alu_t[7:0];
    assign alu_carry  = alu_t[8];

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic ld, input logic [2:0] op, input logic [7:0] v);
        chk("send_ready", 16'(cmd_ready), 16'd1);
        cmd_valid   = 1'b1;
        cmd_load    = ld;
        cmd_opcode  = op;
        cmd_operand = v;
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic ld, input logic [2:0] op,
                         input logic [7:0] v, input logic [7:0] er,
                         input logic ec, input logic ez);
        send(ld, op, v);
        tick;
        if (!ld) begin
            chk({tag, "_exec_opc"}, 16'(alu_opcode), 16'(op));
            chk({tag, "_exec_b"}, 16'(alu_b), 16'(v));
            chk({tag, "_exec_novld"}, 16'(rsp_valid), 16'd0);
            tick;
        end
        chk({tag, "_vld"}, 16'(rsp_valid), 16'd1);
        chk({tag, "_res"}, 16'(rsp_result), 16'(er));
        chk({tag, "_carry"}, 16'(rsp_carry), 16'(ec));
        chk({tag, "_zero"}, 16'(rsp_zero), 16'(ez));
        chk({tag, "_acc"}, 16'(acc), 16'(er));
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk({tag, "_done"}, 16'(rsp_valid), 16'd0);
        chk({tag, "_idle"}, 16'(busy), 16'd0);
    endtask

    logic [7:0] bp_val [6];
    logic [7:0] bp_exp [5];
    int  accepted;
    int  w;
    bit  stopped;

    initial begin
        bp_val = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        bp_exp = '{8'h01, 8'h02, 8'h04, 8'h07, 8'h0B};

        tick;
        tick;
        chk("rst_acc", 16'(acc), 16'd0);
        chk("rst_alu", 16'({alu_a, alu_b, alu_opcode}), 16'd0);
        chk("rst_rsp", 16'({rsp_result, rsp_valid, rsp_carry, rsp_zero}), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        chk("rst_ready", 16'(cmd_ready), 16'd1);

        do_op("ld_f0", 1'b1, 3'd0, 8'hF0, 8'hF0, 1'b0, 1'b0);
        do_op("add_20", 1'b0, 3'd0, 8'h20, 8'h10, 1'b1, 1'b0);

        do_op("ld_05", 1'b1, 3'd0, 8'h05, 8'h05, 1'b0, 1'b0);
        do_op("sub_05", 1'b0, 3'd1, 8'h05, 8'h00, 1'b0, 1'b1);
        do_op("sub_01", 1'b0, 3'd1, 8'h01, 8'hFF, 1'b1, 1'b0);

        do_op("ld_96a", 1'b1, 3'd0, 8'h96, 8'h96, 1'b0, 1'b0);
        do_op("and_3c", 1'b0, 3'd2, 8'h3C, 8'h14, 1'b0, 1'b0);
        do_op("xor_14", 1'b0, 3'd4, 8'h14, 8'h00, 1'b0, 1'b1);
        do_op("ld_96b", 1'b1, 3'd0, 8'h96, 8'h96, 1'b0, 1'b0);
        do_op("or_3c", 1'b0, 3'd3, 8'h3C, 8'hBE, 1'b0, 1'b0);
        do_op("ld_96c", 1'b1, 3'd0, 8'h96, 8'h96, 1'b0, 1'b0);
        do_op("not_a", 1'b0, 3'd5, 8'h3C, 8'h69, 1'b0, 1'b0);
        do_op("inc_a", 1'b0, 3'd6, 8'h3C, 8'h6A, 1'b0, 1'b0);
        do_op("shl_a1", 1'b0, 3'd7, 8'h3C, 8'hD4, 1'b0, 1'b0);
        do_op("shl_a2", 1'b0, 3'd7, 8'h3C, 8'hA8, 1'b1, 1'b0);

        // Backpressure: response stalled, stream commands until refused
        rsp_ready = 1'b0;
        accepted  = 0;
        stopped   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!stopped) begin
                cmd_valid   = 1'b1;
                cmd_load    = (i == 0);
                cmd_opcode  = 3'd0;
                cmd_operand = bp_val[i];
                w = 0;
                while (!cmd_ready && w < 6) begin
                    tick;
                    w++;
                end
                if (cmd_ready) begin
                    tick;
                    accepted++;
                end else begin
                    stopped = 1'b1;
                end
            end
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", 16'(accepted), 16'd5);
        chk("bp_not_ready", 16'(cmd_ready), 16'd0);
        chk("bp_vld", 16'(rsp_valid), 16'd1);
        chk("bp_stable0", 16'(rsp_result), 16'h01);
        tick;
        tick;
        chk("bp_stable1", 16'(rsp_result), 16'h01);
        chk("bp_busy", 16'(busy), 16'd1);

        rsp_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick;
            chk($sformatf("bp_gap%0d", k), 16'(rsp_valid), 16'd0);
            tick;
            chk($sformatf("bp_vld%0d", k), 16'(rsp_valid), 16'd1);
            chk($sformatf("bp_res%0d", k), 16'(rsp_result), 16'(bp_exp[k]));
        end
        tick;
        rsp_ready = 1'b0;
        chk("bp_drained", 16'(rsp_valid), 16'd0);
        chk("bp_idle", 16'(busy), 16'd0);
        chk("bp_acc", 16'(acc), 16'h0B);

        // Reset in the middle of a queued run
        send(1'b1, 3'd0, 8'h11);
        send(1'b0, 3'd0, 8'h22);
        send(1'b0, 3'd0, 8'h33);
        rst = 1'b1;
        tick;
        chk("mrst_acc", 16'(acc), 16'd0);
        chk("mrst_alu", 16'({alu_a, alu_b, alu_opcode}), 16'd0);
        chk("mrst_rsp", 16'({rsp_result, rsp_valid, rsp_carry, rsp_zero}), 16'd0);
        chk("mrst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        chk("mrst_ready", 16'(cmd_ready), 16'd1);
        tick;
        tick;
        chk("mrst_no_rsp", 16'(rsp_valid), 16'd0);
        chk("mrst_still_idle", 16'(busy), 16'd0);

`ifdef ALU_SEQ_STICKY_CARRY_EN
        chk("st_rst", 16'(sticky_carry), 16'd0);
        do_op("st_ld_ff", 1'b1, 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        do_op("st_inc", 1'b0, 3'd6, 8'h00, 8'h00, 1'b1, 1'b1);
        chk("st_set", 16'(sticky_carry), 16'd1);
        do_op("st_and", 1'b0, 3'd2, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("st_hold", 16'(sticky_carry), 16'd1);
        sticky_clr = 1'b1;
        tick;
        sticky_clr = 1'b0;
        chk("st_clr", 16'(sticky_carry), 16'd0);
        do_op("st_ld_ff2", 1'b1, 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        send(1'b0, 3'd6, 8'h00);
        tick;
        sticky_clr = 1'b1;
        tick;
        sticky_clr = 1'b0;
        chk("st_race_vld", 16'(rsp_valid), 16'd1);
        chk("st_race_carry", 16'(rsp_carry), 16'd1);
        chk("st_set_wins", 16'(sticky_carry), 16'd1);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        sticky_clr = 1'b1;
        tick;
        sticky_clr = 1'b0;
        chk("st_clr2", 16'(sticky_carry), 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-side initiator for the team's 8-bit combinational ALU (A, B, 3-bit opcode in; result, carry out). It accepts operation commands over a valid/ready stream, buffers them in a small FIFO and issues them one at a time to the ALU with an internal 8-bit accumulator as operand A. It captures result and carry back into the accumulator and returns each result on a valid/ready response stream. It lets upstream logic run chained ALU programs without knowing the ALU's timing.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of two, >= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_load  input  1  1 = load accumulator with cmd_operand (no ALU op)
cmd_opcode  input  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 inc A, 111 shift-left A by 1
cmd_operand  input  8  operand B (or load value)
alu_a  output  8  to ALU A, registered
alu_b  output  8  to ALU B, registered
alu_opcode  output  3  to ALU opcode, registered
alu_result  input  8  from ALU result
alu_carry  input  1  from ALU carry
rsp_valid  output  1  response present
rsp_ready  input  1  downstream accepts response
rsp_result  output  8  new accumulator value
rsp_carry  output  1  captured carry (0 for load and logic ops, as returned by ALU)
rsp_zero  output  1  rsp_result == 0
acc  output  8  current accumulator
busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, any state): FIFO flushed; state IDLE; acc, alu_a, alu_b, alu_opcode, rsp_result = 0; rsp_valid, rsp_carry, rsp_zero, busy = 0; cmd_ready = 1 once rst is low. In-flight command is discarded with no response.
- FIFO push when cmd_valid & cmd_ready. cmd_ready = !full (combinational from count). Simultaneous push and pop is allowed when not full. When full, cmd_ready = 0 even if a pop occurs that cycle.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if FIFO non-empty, pop head at edge.
  - ALU op: alu_a <= acc, alu_b <= operand, alu_opcode <= opcode; go EXEC.
  - Load: acc <= operand; rsp_result <= operand, rsp_carry <= 0, rsp_zero <= (operand == 0), rsp_valid <= 1; go RESP.
- EXEC: one cycle, ALU inputs stable all cycle. At end edge: acc <= alu_result, rsp_result <= alu_result, rsp_carry <= alu_carry, rsp_zero <= (alu_result == 0), rsp_valid <= 1; go RESP.
- RESP: rsp_* held stable while rsp_valid & !rsp_ready. On rsp_valid & rsp_ready edge: rsp_valid <= 0. If FIFO non-empty, pop and issue directly (EXEC or load-to-RESP, same edge); else go IDLE.
- alu_a/b/opcode hold last issued values outside EXEC.
- Latency: command pushed at edge N into an empty idle block gives rsp_valid at N+2 for ALU ops and N+1 for loads. Sustained throughput is 1 ALU op per 2 cycles with rsp_ready = 1.
- Ordering: responses strictly in command order. Acc is updated before the response is issued, so the next command uses it.
- Max accepted while response stalled: FIFO_DEPTH + 1 (one in RESP).

Optional Feature:
ALU_SEQ_STICKY_CARRY_EN
- Defined: adds output sticky_carry (1) and input sticky_clr (1).
  - sticky_carry sets on any edge where rsp_carry is loaded with 1.
  - It clears on sticky_clr; set wins if both occur on the same edge.
  - Reset value 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-run with cmds queued -> all outputs 0 next cycle, cmd_ready = 1 after release, no stray rsp_valid.
- Load 0xF0 then add 0x20 (ALU model attached) -> responses 0xF0 c0 z0, then 0x10 c1 z0; acc = 0x10; add rsp_valid 2 cycles after its issue.
- Load 0x05, sub 0x05, sub 0x01 -> 0x05, then 0x00 z1 c0, then 0xFF c1 z0.
- Backpressure: rsp_ready = 0, stream cmds -> exactly 5 accepted (FIFO_DEPTH = 4) before cmd_ready = 0; rsp_result stable. Raise rsp_ready -> 5 responses in order, back-to-back at 2-cycle spacing.
- Ops 010..111 on acc = 0x96 with operand 0x3C -> and 0x14; xor with 0x14 gives 0x00 z1; not A, inc A, shift-left results match the ALU model exactly; alu_opcode equals the command opcode during EXEC.
- ALU_SEQ_STICKY_CARRY_EN: load 0xFF, inc -> sticky_carry = 1; subsequent and op leaves it at 1; sticky_clr on same edge as a carry=1 capture -> remains 1; clr alone -> 0.
